// File: rtl/tlp_f2c_dma_writer.sv
// FPGA->CPU DMA writer: packs a 64-bit stream into 3DW memory-write TLPs
// aimed at a circular host buffer, posting the write pointer after each chunk.
`timescale 1ns/1ps
module tlp_f2c_dma_writer #(
  parameter int TLPSIZE_NBITS   = 7,
  parameter int CHUNKSIZE_NBITS = 9,
  parameter int SIZE_NBITS      = 12,
  localparam int PTR_W = SIZE_NBITS - CHUNKSIZE_NBITS
) (
  input  logic             pcieClk_in,
  input  logic             pcieReset_in,
  input  logic [15:0]      cfgBusDev_in,
  input  logic             enable_in,
  input  logic [29:0]      f2cBase_in,
  input  logic [29:0]      mtrBase_in,
  input  logic [PTR_W-1:0] rdPtr_in,
  input  logic [63:0]      f2cData_in,
  input  logic             f2cValid_in,
  output logic             f2cReady_out,
  output logic [63:0]      tx_data_out,
  output logic             tx_valid_out,
  input  logic             tx_ready_in,
  output logic             tx_sop_out,
  output logic             tx_eop_out,
  output logic [PTR_W-1:0] wrPtr_out
);

  localparam int TLP_DW = 2 ** (TLPSIZE_NBITS - 2);
  localparam int TLP_QW = TLP_DW / 2;
  localparam int TLPS_PER_CHUNK = 2 ** (CHUNKSIZE_NBITS - TLPSIZE_NBITS);
  localparam int CHUNK_DW = 2 ** (CHUNKSIZE_NBITS - 2);
  localparam int IDX_W = (CHUNKSIZE_NBITS > TLPSIZE_NBITS) ?
                         (CHUNKSIZE_NBITS - TLPSIZE_NBITS) : 1;
  localparam int QW_W = TLPSIZE_NBITS - 2;

  localparam logic [2:0] FMT_H3DW_WITHDATA = 3'b010;
  localparam logic [4:0] TYPE_MEM_RW_REQ   = 5'b00000;

  localparam logic [9:0]       DATA_LEN = 10'(TLP_DW);
  localparam logic [QW_W-1:0]  LAST_QW  = QW_W'(TLP_QW - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLPS_PER_CHUNK - 1);
  localparam logic [29:0]      CHUNK_STRIDE = 30'(CHUNK_DW);
  localparam logic [29:0]      TLP_STRIDE   = 30'(TLP_DW);

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, BODY, TAIL, MTR0, MTR1
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] wr_ptr;
  logic [IDX_W-1:0] tlp_idx;
  logic [31:0]      hold;
  logic [QW_W-1:0]  qw_cnt;

  logic        full;
  logic        tx_fire;
  logic [29:0] dma_addr;

  // Write0 QW: lower DW is the fmt/type/length word, upper DW the ID/BE word.
  function automatic logic [63:0] wr0_qw(
    input logic [9:0]  len,
    input logic [3:0]  last_be,
    input logic [15:0] req_id
  );
    return {req_id, 8'h00, last_be, 4'hF,
            FMT_H3DW_WITHDATA, TYPE_MEM_RW_REQ,
            8'h00, 6'b000000, len};
  endfunction

  assign full     = (wr_ptr + PTR_W'(1)) == rdPtr_in;
  assign tx_fire  = tx_valid_out && tx_ready_in;
  assign dma_addr = f2cBase_in
                  + 30'(wr_ptr) * CHUNK_STRIDE
                  + 30'(tlp_idx) * TLP_STRIDE;
  assign wrPtr_out = wr_ptr;

  always_comb begin
    tx_valid_out = 1'b0;
    tx_sop_out   = 1'b0;
    tx_eop_out   = 1'b0;
    tx_data_out  = '0;
    f2cReady_out = 1'b0;
    unique case (state)
      IDLE: ;
      HDR0: begin
        tx_valid_out = 1'b1;
        tx_sop_out   = 1'b1;
        tx_data_out  = wr0_qw(DATA_LEN, 4'hF, cfgBusDev_in);
      end
      HDR1: begin
        tx_valid_out = f2cValid_in;
        f2cReady_out = tx_ready_in;
        tx_data_out  = {f2cData_in[31:0], dma_addr, 2'b00};
      end
      BODY: begin
        tx_valid_out = f2cValid_in;
        f2cReady_out = tx_ready_in;
        tx_data_out  = {f2cData_in[31:0], hold};
      end
      TAIL: begin
        tx_valid_out = 1'b1;
        tx_eop_out   = 1'b1;
        tx_data_out  = {32'h0, hold};
      end
      MTR0: begin
        tx_valid_out = 1'b1;
        tx_sop_out   = 1'b1;
        tx_data_out  = wr0_qw(10'd1, 4'h0, cfgBusDev_in);
      end
      MTR1: begin
        tx_valid_out = 1'b1;
        tx_eop_out   = 1'b1;
        tx_data_out  = {32'(wr_ptr), mtrBase_in, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge pcieClk_in or posedge pcieReset_in) begin
    if (pcieReset_in) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      tlp_idx <= '0;
      hold    <= '0;
      qw_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // a started chunk always runs to completion
          if (tlp_idx != '0 || (enable_in && !full))
            state <= HDR0;
        end
        HDR0: begin
          if (tx_fire)
            state <= HDR1;
        end
        HDR1: begin
          if (tx_fire) begin
            hold   <= f2cData_in[63:32];
            qw_cnt <= QW_W'(1);
            state  <= (TLP_QW == 1) ? TAIL : BODY;
          end
        end
        BODY: begin
          if (tx_fire) begin
            hold   <= f2cData_in[63:32];
            qw_cnt <= qw_cnt + QW_W'(1);
            if (qw_cnt == LAST_QW)
              state <= TAIL;
          end
        end
        TAIL: begin
          if (tx_fire) begin
            if (tlp_idx == LAST_IDX) begin
              tlp_idx <= '0;
              wr_ptr  <= wr_ptr + PTR_W'(1);
              state   <= MTR0;
            end else begin
              tlp_idx <= tlp_idx + IDX_W'(1);
              state   <= HDR0;
            end
          end
        end
        MTR0: begin
          if (tx_fire)
            state <= MTR1;
        end
        MTR1: begin
          if (tx_fire)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlp_f2c_dma_writer.sv
// Randomised bench for tlp_f2c_dma_writer against a packet-level model
// that builds whole expected chunks from the payload stream.
`timescale 1ns/1ps
module tb_tlp_f2c_dma_writer;

  localparam int TN  = 7;
  localparam int CN  = 9;
  localparam int SN  = 12;
  localparam int PW  = SN - CN;
  localparam int NCH = 2 ** PW;
  localparam int TDW = 2 ** (TN - 2);
  localparam int TQW = TDW / 2;
  localparam int TPC = 2 ** (CN - TN);
  localparam int CDW = 2 ** (CN - 2);
  localparam int CQW = CDW / 2;
  localparam int CBEATS = TPC * (TQW + 2) + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   cfg_bus_dev = '0;
  logic          enable = 1'b0;
  logic [29:0]   f2c_base = '0;
  logic [29:0]   mtr_base = '0;
  logic [PW-1:0] rd_ptr = '0;
  logic [63:0]   f2c_data = '0;
  logic          f2c_valid = 1'b0;
  logic          f2c_ready;
  logic [63:0]   tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          tx_sop;
  logic          tx_eop;
  logic [PW-1:0] wr_ptr;

  tlp_f2c_dma_writer #(
    .TLPSIZE_NBITS(TN), .CHUNKSIZE_NBITS(CN), .SIZE_NBITS(SN)
  ) dut (
    .pcieClk_in(clk), .pcieReset_in(rst), .cfgBusDev_in(cfg_bus_dev),
    .enable_in(enable), .f2cBase_in(f2c_base), .mtrBase_in(mtr_base),
    .rdPtr_in(rd_ptr), .f2cData_in(f2c_data), .f2cValid_in(f2c_valid),
    .f2cReady_out(f2c_ready), .tx_data_out(tx_data),
    .tx_valid_out(tx_valid), .tx_ready_in(tx_ready),
    .tx_sop_out(tx_sop), .tx_eop_out(tx_eop), .wrPtr_out(wr_ptr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [63:0] d;
  } beat_t;

  beat_t       mon[$];
  beat_t       exp_q[$];
  logic [63:0] src_q[$];
  logic [63:0] dat[$];
  bit          src_rand, tx_rand, src_hold;
  int          total, bad;

  task automatic tick();
    @(posedge clk); #1;
    f2c_valid = (src_q.size() > 0) &&
                (src_hold || !src_rand || $urandom_range(1) == 1);
    f2c_data  = (src_q.size() > 0) ? src_q[0] : 64'h0;
    tx_ready  = !tx_rand || $urandom_range(1) == 1;
    @(negedge clk);
    if (tx_valid && tx_ready)
      mon.push_back({tx_sop, tx_eop, tx_data});
    if (f2c_valid && f2c_ready) begin
      void'(src_q.pop_front());
      src_hold = 1'b0;
    end else begin
      src_hold = f2c_valid;
    end
  endtask

  task automatic run_beats(input int n, input int maxc);
    for (int c = 0; c < maxc && mon.size() < n; c++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    f2c_valid = 1'b0;
    f2c_data = '0;
    tx_ready = 1'b0;
    src_hold = 1'b0;
    src_rand = 1'b0;
    tx_rand = 1'b0;
    src_q.delete();
    mon.delete();
    exp_q.delete();
    dat.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic configure();
    cfg_bus_dev = 16'h0100;
    f2c_base = 30'h1000;
    mtr_base = 30'h2000;
    rd_ptr = '0;
    enable = 1'b1;
  endtask

  task automatic add_data(input int n, input bit seq);
    logic [63:0] q;
    for (int k = 0; k < n; k++) begin
      if (seq)
        q = {32'(2 * dat.size() + 1), 32'(2 * dat.size())};
      else
        q = {$urandom, $urandom};
      dat.push_back(q);
      src_q.push_back(q);
    end
  endtask

  function automatic logic [63:0] hdr(input int len, input logic [3:0] lbe);
    logic [9:0] l;
    l = len[9:0];
    return {cfg_bus_dev, 8'h00, lbe, 4'hF, 8'h40, 8'h00, 6'b0, l};
  endfunction

  function automatic logic [31:0] pdw(input int first, input int j);
    logic [63:0] q;
    q = dat[first + j / 2];
    return (j % 2 == 1) ? q[63:32] : q[31:0];
  endfunction

  // One chunk: TPC data TLPs from a DW stream, then the pointer post.
  function automatic void model_chunk(input int ptr, input int first);
    logic [29:0] a;
    int b;
    for (int t = 0; t < TPC; t++) begin
      b = t * TDW;
      a = f2c_base + 30'(ptr * CDW + b);
      exp_q.push_back({2'b10, hdr(TDW, 4'hF)});
      exp_q.push_back({2'b00, pdw(first, b), a, 2'b00});
      for (int i = 1; i < TQW; i++)
        exp_q.push_back({2'b00, pdw(first, b + 2 * i), pdw(first, b + 2 * i - 1)});
      exp_q.push_back({2'b01, 32'h0, pdw(first, b + TDW - 1)});
    end
    exp_q.push_back({2'b10, hdr(1, 4'h0)});
    exp_q.push_back({2'b01, 32'((ptr + 1) % NCH), mtr_base, 2'b00});
  endfunction

  task automatic test_reset();
    #2;
    total++;
    if (tx_valid !== 1'b0) begin
      bad++; $display("FAIL reset_tx_valid got %b want 0", tx_valid);
    end
    total++;
    if (f2c_ready !== 1'b0) begin
      bad++; $display("FAIL reset_f2c_ready got %b want 0", f2c_ready);
    end
    total++;
    if ({tx_sop, tx_eop} !== 2'b00) begin
      bad++; $display("FAIL reset_sop_eop got %b want 00", {tx_sop, tx_eop});
    end
    total++;
    if (tx_data !== 64'h0) begin
      bad++; $display("FAIL reset_tx_data got %h want 0", tx_data);
    end
    total++;
    if (wr_ptr !== '0) begin
      bad++; $display("FAIL reset_wr_ptr got %0d want 0", wr_ptr);
    end
    do_reset();
  endtask

  task automatic test_header();
    logic [63:0] d;
    beat_t e;
    do_reset();
    configure();
    add_data(CQW, 1'b1);
    run_beats(TQW + 2, 300);
    total++;
    if (mon.size() < TQW + 2) begin
      bad++; $display("FAIL header_count got %0d want %0d", mon.size(), TQW + 2);
    end
    for (int i = 0; i < TQW + 2 && i < mon.size(); i++) begin
      if (i == 0) d = 64'h0100_00FF_4000_0020;
      else if (i == 1) d = 64'h0000_0000_0000_4000;
      else if (i == TQW + 1) d = {32'h0, 32'd31};
      else d = {32'(2 * (i - 2) + 2), 32'(2 * (i - 2) + 1)};
      e = {i == 0, i == TQW + 1, d};
      total++;
      if (mon[i] !== e) begin
        bad++; $display("FAIL header_beat%0d got %h want %h", i, mon[i], e);
      end
    end
  endtask

  task automatic test_rollover();
    do_reset();
    configure();
    add_data(CQW, 1'b1);
    model_chunk(0, 0);
    run_beats(CBEATS, 1000);
    total++;
    if (mon.size() !== CBEATS) begin
      bad++; $display("FAIL roll_count got %0d want %0d", mon.size(), CBEATS);
    end
    for (int i = 0; i < exp_q.size() && i < mon.size(); i++) begin
      total++;
      if (mon[i] !== exp_q[i]) begin
        bad++; $display("FAIL roll_beat%0d got %h want %h", i, mon[i], exp_q[i]);
      end
    end
    for (int t = 0; t < TPC && (TQW + 2) * t + 1 < mon.size(); t++) begin
      total++;
      if (mon[(TQW + 2) * t + 1].d[31:0] !== 32'((32'h1000 + 32'h20 * t) << 2)) begin
        bad++; $display("FAIL roll_addr%0d got %h want %h", t,
          mon[(TQW + 2) * t + 1].d[31:0], (32'h1000 + 32'h20 * t) << 2);
      end
    end
    if (mon.size() >= CBEATS) begin
      total++;
      if (mon[CBEATS - 2].d !== 64'h0100_000F_4000_0001) begin
        bad++; $display("FAIL roll_mtr0 got %h want 0100000f40000001", mon[CBEATS - 2].d);
      end
      total++;
      if (mon[CBEATS - 1].d !== 64'h0000_0001_0000_8000) begin
        bad++; $display("FAIL roll_mtr1 got %h want 0000000100008000", mon[CBEATS - 1].d);
      end
    end
    total++;
    if (wr_ptr !== PW'(1)) begin
      bad++; $display("FAIL roll_wr_ptr got %0d want 1", wr_ptr);
    end
  endtask

  task automatic test_full();
    do_reset();
    configure();
    add_data(NCH * CQW, 1'b0);
    for (int p = 0; p < NCH - 1; p++) model_chunk(p, p * CQW);
    run_beats((NCH - 1) * CBEATS, 4000);
    repeat (40) tick();
    total++;
    if (mon.size() !== (NCH - 1) * CBEATS) begin
      bad++; $display("FAIL full_stall_count got %0d want %0d", mon.size(), (NCH - 1) * CBEATS);
    end
    total++;
    if ({tx_valid, f2c_ready} !== 2'b00) begin
      bad++; $display("FAIL full_idle got %b want 00", {tx_valid, f2c_ready});
    end
    total++;
    if (wr_ptr !== PW'(NCH - 1)) begin
      bad++; $display("FAIL full_wr_ptr got %0d want %0d", wr_ptr, NCH - 1);
    end
    rd_ptr = PW'(1);
    model_chunk(NCH - 1, (NCH - 1) * CQW);
    run_beats(NCH * CBEATS, 1000);
    repeat (20) tick();
    total++;
    if (mon.size() !== NCH * CBEATS) begin
      bad++; $display("FAIL full_resume_count got %0d want %0d", mon.size(), NCH * CBEATS);
    end
    for (int i = 0; i < exp_q.size() && i < mon.size(); i++) begin
      total++;
      if (mon[i] !== exp_q[i]) begin
        bad++; $display("FAIL full_beat%0d got %h want %h", i, mon[i], exp_q[i]);
      end
    end
    total++;
    if (wr_ptr !== '0) begin
      bad++; $display("FAIL full_wrap got %0d want 0", wr_ptr);
    end
  endtask

  task automatic test_backpressure();
    logic [66:0] cur, prev;
    bit stall;
    do_reset();
    configure();
    add_data(CQW, 1'b1);
    model_chunk(0, 0);
    src_rand = 1'b1;
    tx_rand = 1'b1;
    stall = 1'b0;
    prev = '0;
    for (int c = 0; c < 4000 && mon.size() < CBEATS; c++) begin
      tick();
      cur = {tx_valid, tx_sop, tx_eop, tx_data};
      if (stall) begin
        total++;
        if (cur !== prev) begin
          bad++; $display("FAIL bp_stable cyc%0d got %h want %h", c, cur, prev);
        end
      end
      stall = tx_valid && !tx_ready;
      prev = cur;
    end
    src_rand = 1'b0;
    tx_rand = 1'b0;
    total++;
    if (mon.size() !== CBEATS) begin
      bad++; $display("FAIL bp_count got %0d want %0d", mon.size(), CBEATS);
    end
    for (int i = 0; i < exp_q.size() && i < mon.size(); i++) begin
      total++;
      if (mon[i] !== exp_q[i]) begin
        bad++; $display("FAIL bp_beat%0d got %h want %h", i, mon[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_disable();
    do_reset();
    configure();
    add_data(2 * CQW, 1'b0);
    model_chunk(0, 0);
    run_beats(2 * (TQW + 2), 500);
    enable = 1'b0;
    run_beats(CBEATS, 500);
    repeat (50) tick();
    total++;
    if (mon.size() !== CBEATS) begin
      bad++; $display("FAIL dis_count got %0d want %0d", mon.size(), CBEATS);
    end
    for (int i = 0; i < exp_q.size() && i < mon.size(); i++) begin
      total++;
      if (mon[i] !== exp_q[i]) begin
        bad++; $display("FAIL dis_beat%0d got %h want %h", i, mon[i], exp_q[i]);
      end
    end
    total++;
    if ({tx_valid, f2c_ready, wr_ptr} !== {2'b00, PW'(1)}) begin
      bad++; $display("FAIL dis_idle got %b want %b", {tx_valid, f2c_ready, wr_ptr}, {2'b00, PW'(1)});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    configure();
    add_data(2 * CQW, 1'b0);
    run_beats(CBEATS + 6, 800);
    total++;
    if (wr_ptr !== PW'(1)) begin
      bad++; $display("FAIL rmid_pre_wr_ptr got %0d want 1", wr_ptr);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({tx_valid, f2c_ready, tx_sop, tx_eop} !== 4'b0000) begin
      bad++; $display("FAIL rmid_outputs got %b want 0000", {tx_valid, f2c_ready, tx_sop, tx_eop});
    end
    total++;
    if (wr_ptr !== '0) begin
      bad++; $display("FAIL rmid_wr_ptr got %0d want 0", wr_ptr);
    end
    do_reset();
    configure();
    add_data(CQW, 1'b0);
    model_chunk(0, 0);
    run_beats(CBEATS, 1000);
    total++;
    if (mon.size() !== CBEATS) begin
      bad++; $display("FAIL rmid_count got %0d want %0d", mon.size(), CBEATS);
    end
    if (mon.size() > 1) begin
      total++;
      if (mon[1].d[31:0] !== 32'h0000_4000) begin
        bad++; $display("FAIL rmid_addr got %h want 00004000", mon[1].d[31:0]);
      end
    end
    for (int i = 0; i < exp_q.size() && i < mon.size(); i++) begin
      total++;
      if (mon[i] !== exp_q[i]) begin
        bad++; $display("FAIL rmid_beat%0d got %h want %h", i, mon[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_header();
    test_rollover();
    test_full();
    test_backpressure();
    test_disable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
